// File: rtl/oled_pkg.sv
// Shared definitions for the 80x60 OLED pixel path.
//   - Default display geometry.
//   - RGB565 field positions.
//   - Camera writer FSM state encoding.
//   - Constant-multiply helper built from shifts and adds.
package oled_pkg;

    localparam int c_def_x_size = 80;
    localparam int c_def_y_size = 60;

    // RGB565 = {R[4:0], G[5:0], B[4:0]}
    localparam int c_r_msb = 15;
    localparam int c_r_lsb = 11;
    localparam int c_g_msb = 10;
    localparam int c_g_lsb = 5;
    localparam int c_b_msb = 4;
    localparam int c_b_lsb = 0;

    localparam logic [0:0] WAIT_FRAME = 1'b0;
    localparam logic [0:0] ACTIVE     = 1'b1;

    // a * c, where c is an elaboration-time constant.
    // Each set bit of c contributes one shifted copy of a, so this reduces
    // to a short adder chain (80 = 64 + 16 -> two terms).
    function automatic int unsigned shift_add_mul(input int unsigned a,
                                                  input int unsigned c);
        int unsigned acc;
        acc = 0;
        for (int i = 0; i < 32; i++) begin
            if (c[i]) acc = acc + (a << i);
        end
        return acc;
    endfunction

endpackage

// File: rtl/fb_dpram.sv
// Simple dual-port RAM with a registered read port (BRAM-inferable).
//   clk      : single clock for both ports
//   we       : write enable
//   wr_addr  : write address
//   wr_data  : write data
//   rd_addr  : read address, sampled every cycle
//   rd_data  : data at rd_addr from the previous cycle
// Contents are not reset.
module fb_dpram #(
    parameter int c_depth = 2,
    parameter int c_width = 16,
    parameter int c_aw    = $clog2(c_depth)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [c_aw-1:0]    wr_addr,
    input  logic [c_width-1:0] wr_data,
    input  logic [c_aw-1:0]    rd_addr,
    output logic [c_width-1:0] rd_data
);

    logic [c_width-1:0] mem_q [c_depth];
    logic [c_width-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (we) mem_q[wr_addr] <= wr_data;
        rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/cam_fb_downscale.sv
// Camera-to-OLED downscaler with a tear-free double-buffered framebuffer.
// A camera RGB565 stream is box-averaged horizontally over c_scale pixels
// and decimated vertically (one row in c_scale kept), then written to the
// write bank. The OLED core reads the read bank by x/y. Banks exchange only
// when the display is at (0,0) and a finished frame is waiting.
//   clk, reset       : shared clock, synchronous active-high reset
//   cam_frame_start  : pulse before the first pixel of a camera frame
//   cam_valid        : cam_pixel valid this cycle
//   cam_pixel        : RGB565 source pixel
//   x, y, next_pixel : display scan position and advance pulse
//   color            : RGB565 at (x,y) of the read bank, one cycle later
//   swap_pending     : finished frame waiting for the display boundary
//   frames_done      : finished write frames (wraps)
//   frames_dropped   : finished frames overwritten before display (wraps)
module cam_fb_downscale
    import oled_pkg::*;
#(
    parameter int c_src_x_size = 640,
    parameter int c_src_y_size = 480,
    parameter int c_scale      = 8,
    parameter int c_x_size     = c_def_x_size,
    parameter int c_y_size     = c_def_y_size,
    parameter int c_x_bits     = $clog2(c_x_size),
    parameter int c_y_bits     = $clog2(c_y_size)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cam_frame_start,
    input  logic                cam_valid,
    input  logic [15:0]         cam_pixel,
    input  logic [c_x_bits-1:0] x,
    input  logic [c_y_bits-1:0] y,
    input  logic                next_pixel,
    output logic [15:0]         color,
    output logic                swap_pending,
    output logic [7:0]          frames_done,
    output logic [7:0]          frames_dropped
);

    localparam int c_k       = $clog2(c_scale);
    localparam int c_rw      = 5 + c_k;
    localparam int c_gw      = 6 + c_k;
    localparam int c_sx_bits = $clog2(c_src_x_size);
    localparam int c_sy_bits = $clog2(c_src_y_size);
    localparam int c_pix     = c_x_size * c_y_size;
    localparam int c_depth   = 2 * c_pix;
    localparam int c_ram_aw  = $clog2(c_depth);

    logic [0:0]           state_q, state_d;
    logic [c_sx_bits-1:0] src_x_q, src_x_d;
    logic [c_sy_bits-1:0] src_y_q, src_y_d;
    logic [c_rw-1:0]      r_acc_q, r_acc_d, r_sum;
    logic [c_gw-1:0]      g_acc_q, g_acc_d, g_sum;
    logic [c_rw-1:0]      b_acc_q, b_acc_d, b_sum;
    logic                 wr_bank_q, wr_bank_d;
    logic                 swap_pending_q, swap_pending_d;
    logic [7:0]           frames_done_q, frames_done_d;
    logic [7:0]           frames_dropped_q, frames_dropped_d;
    logic                 rd_ok_q, rd_ok_d;

    logic pix_ok, last_col, last_row, keep_row, win_close, frame_done;
    logic swap, pend_kept, in_range;
    int unsigned wr_off, rd_off;

    logic                ram_we;
    logic [c_ram_aw-1:0] ram_wr_addr, ram_rd_addr;
    logic [15:0]         ram_wr_data, ram_rd_data;

    // ---------------- camera writer ----------------
    always_comb begin
        state_d = state_q;
        src_x_d = src_x_q;
        src_y_d = src_y_q;
        r_acc_d = r_acc_q;
        g_acc_d = g_acc_q;
        b_acc_d = b_acc_q;

        r_sum = r_acc_q + c_rw'(cam_pixel[c_r_msb:c_r_lsb]);
        g_sum = g_acc_q + c_gw'(cam_pixel[c_g_msb:c_g_lsb]);
        b_sum = b_acc_q + c_rw'(cam_pixel[c_b_msb:c_b_lsb]);

        // A frame_start pulse always wins over a pixel in the same cycle.
        pix_ok    = (state_q == ACTIVE) && cam_valid && !cam_frame_start;
        last_col  = (src_x_q == c_sx_bits'(c_src_x_size - 1));
        last_row  = (src_y_q == c_sy_bits'(c_src_y_size - 1));
        keep_row  = (src_y_q[c_k-1:0] == '0);
        win_close = (src_x_q[c_k-1:0] == '1);
        frame_done = 1'b0;

        // Destination is (src >> k); the divide-by-c_scale of the average
        // is just taking the upper field bits of each sum.
        wr_off      = shift_add_mul(32'(src_y_q >> c_k), c_x_size) + 32'(src_x_q >> c_k);
        ram_wr_addr = c_ram_aw'(wr_bank_q ? wr_off + c_pix : wr_off);
        ram_wr_data = {r_sum[c_k +: 5], g_sum[c_k +: 6], b_sum[c_k +: 5]};
        ram_we      = 1'b0;

        if (cam_frame_start) begin
            // Also the abort path: a partial frame is simply abandoned.
            state_d = ACTIVE;
            src_x_d = '0;
            src_y_d = '0;
            r_acc_d = '0;
            g_acc_d = '0;
            b_acc_d = '0;
        end else if (pix_ok) begin
            if (last_col) begin
                src_x_d = '0;
                src_y_d = src_y_q + 1'b1;
            end else begin
                src_x_d = src_x_q + 1'b1;
            end
            if (keep_row) begin
                if (win_close) begin
                    ram_we  = 1'b1;
                    r_acc_d = '0;
                    g_acc_d = '0;
                    b_acc_d = '0;
                end else begin
                    r_acc_d = r_sum;
                    g_acc_d = g_sum;
                    b_acc_d = b_sum;
                end
            end
            if (last_col && last_row) begin
                frame_done = 1'b1;
                state_d    = WAIT_FRAME;
            end
        end
    end

    // ---------------- bank control ----------------
    always_comb begin
        swap      = next_pixel && (x == '0) && (y == '0) && swap_pending_q;
        wr_bank_d = wr_bank_q ^ swap;
        // Swap is resolved first; a frame finishing on the swap cycle then
        // sees no pending frame and is not counted as a drop.
        pend_kept        = swap_pending_q && !swap;
        swap_pending_d   = pend_kept;
        frames_done_d    = frames_done_q;
        frames_dropped_d = frames_dropped_q;
        if (frame_done) begin
            frames_done_d  = frames_done_q + 8'd1;
            swap_pending_d = 1'b1;
            if (pend_kept) frames_dropped_d = frames_dropped_q + 8'd1;
        end
    end

    // ---------------- display read ----------------
    always_comb begin
        in_range    = (32'(x) < c_x_size) && (32'(y) < c_y_size);
        rd_off      = shift_add_mul(32'(y), c_x_size) + 32'(x);
        rd_ok_d     = in_range;
        ram_rd_addr = '0;
        // Read bank is the other bank after this cycle's swap, so the
        // swap cycle already reads the new frame.
        if (in_range) ram_rd_addr = c_ram_aw'(wr_bank_d ? rd_off : rd_off + c_pix);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= WAIT_FRAME;
            src_x_q          <= '0;
            src_y_q          <= '0;
            r_acc_q          <= '0;
            g_acc_q          <= '0;
            b_acc_q          <= '0;
            wr_bank_q        <= 1'b0;
            swap_pending_q   <= 1'b0;
            frames_done_q    <= '0;
            frames_dropped_q <= '0;
            rd_ok_q          <= 1'b0;
        end else begin
            state_q          <= state_d;
            src_x_q          <= src_x_d;
            src_y_q          <= src_y_d;
            r_acc_q          <= r_acc_d;
            g_acc_q          <= g_acc_d;
            b_acc_q          <= b_acc_d;
            wr_bank_q        <= wr_bank_d;
            swap_pending_q   <= swap_pending_d;
            frames_done_q    <= frames_done_d;
            frames_dropped_q <= frames_dropped_d;
            rd_ok_q          <= rd_ok_d;
        end
    end

    fb_dpram #(
        .c_depth (c_depth),
        .c_width (16),
        .c_aw    (c_ram_aw)
    ) u_fb (
        .clk     (clk),
        .we      (ram_we),
        .wr_addr (ram_wr_addr),
        .wr_data (ram_wr_data),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_rd_data)
    );

    // The RAM output register carries the pixel; rd_ok_q (reset to 0)
    // blanks it for out-of-range reads and out of reset.
    assign color          = rd_ok_q ? ram_rd_data : 16'h0000;
    assign swap_pending   = swap_pending_q;
    assign frames_done    = frames_done_q;
    assign frames_dropped = frames_dropped_q;

endmodule

// File: tb/tb_cam_fb_downscale.sv
// Scoreboard bench for cam_fb_downscale on a reduced geometry
// (80x48 source, scale 8, 10x6 display) to keep frames short.
module tb_cam_fb_downscale;

  localparam int SX = 80, SY = 48, S = 8, K = 3;
  localparam int XS = 10, YS = 6, XB = 4, YB = 3, NP = XS * YS;

  logic          clk = 1'b0;
  logic          reset, cam_frame_start, cam_valid, next_pixel;
  logic [15:0]   cam_pixel, color;
  logic [XB-1:0] x;
  logic [YB-1:0] y;
  logic          swap_pending;
  logic [7:0]    frames_done, frames_dropped;

  always #5 clk = ~clk;

  cam_fb_downscale #(
    .c_src_x_size(SX), .c_src_y_size(SY), .c_scale(S),
    .c_x_size(XS), .c_y_size(YS)
  ) dut (
    .clk(clk), .reset(reset), .cam_frame_start(cam_frame_start),
    .cam_valid(cam_valid), .cam_pixel(cam_pixel), .x(x), .y(y),
    .next_pixel(next_pixel), .color(color), .swap_pending(swap_pending),
    .frames_done(frames_done), .frames_dropped(frames_dropped)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] col;
    bit          col_en;
    int          px, py;
    logic        pend;
    logic [7:0]  done, drop;
  } sb_t;
  sb_t sb_q[$];

  // reference model
  logic [15:0] shown[NP], pend_img[NP], new_img[NP];
  bit   shown_ok, m_pend, last_pix, scan_en;
  int   m_done, m_drop, scx, scy, cx, cy, cur_kind;
  logic [15:0] cur_const;

  function automatic logic [15:0] pix(input int kind, input logic [15:0] cval, input int sx, input int sy);
    logic [31:0] h;
    case (kind)
      0: return cval;
      1: return (sy == 0 && sx < 8) ? ((sx % 2 == 0) ? 16'h001F : 16'h0000) : 16'h07E0;
      default: begin
        h = 32'(sx * 37 + sy * 101 + sx * sy * 13);
        return h[15:0];
      end
    endcase
  endfunction

  task automatic calc_img(input int kind);
    int r, g, b;
    logic [15:0] v;
    for (int yd = 0; yd < YS; yd++)
      for (int xd = 0; xd < XS; xd++) begin
        r = 0; g = 0; b = 0;
        for (int i = 0; i < S; i++) begin
          v = pix(kind, cur_const, xd * S + i, yd * S);
          r += int'(v[15:11]); g += int'(v[10:5]); b += int'(v[4:0]);
        end
        new_img[yd * XS + xd] = {5'(r >> K), 6'(g >> K), 5'(b >> K)};
      end
  endtask

  // One clock: drive display side, update model, push expectation,
  // advance the clock and compare at the falling edge.
  task automatic clk_cycle();
    sb_t e, o;
    if (scan_en) begin
      cx = scx; cy = scy;
      x = XB'(cx); y = YB'(cy); next_pixel = 1'b1;
      scx++;
      if (scx == 16) begin scx = 0; scy = (scy + 1) % 8; end
    end else begin
      next_pixel = 1'b0;
    end
    if (next_pixel && cx == 0 && cy == 0 && m_pend) begin
      shown = pend_img; shown_ok = 1; m_pend = 0;
    end
    e.px = cx; e.py = cy;
    if (cx >= XS || cy >= YS) begin e.col = 16'h0; e.col_en = 1; end
    else begin e.col = shown[cy * XS + cx]; e.col_en = shown_ok; end
    if (last_pix) begin
      m_done = (m_done + 1) % 256;
      if (m_pend) m_drop = (m_drop + 1) % 256;
      calc_img(cur_kind);
      pend_img = new_img; m_pend = 1;
    end
    e.pend = m_pend; e.done = 8'(m_done); e.drop = 8'(m_drop);
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    o = sb_q.pop_front();
    if (o.col_en) chk($sformatf("color(%0d,%0d)", o.px, o.py), 32'(color), 32'(o.col));
    chk("swap_pending", 32'(swap_pending), 32'(o.pend));
    chk("frames_done", 32'(frames_done), 32'(o.done));
    chk("frames_dropped", 32'(frames_dropped), 32'(o.drop));
  endtask

  task automatic send_frame(input int kind, input logic [15:0] cval, input int abort_row);
    cur_kind = kind; cur_const = cval;
    cam_frame_start = 1; cam_valid = 0; clk_cycle();
    cam_frame_start = 0;
    for (int sy = 0; sy < SY; sy++)
      for (int sx = 0; sx < SX; sx++) begin
        if (sy == abort_row) begin cam_valid = 0; return; end
        if ($urandom_range(0, 15) == 0) begin
          cam_valid = 0; cam_pixel = 16'hDEAD; clk_cycle();
        end
        cam_valid = 1; cam_pixel = pix(kind, cval, sx, sy);
        last_pix = (sx == SX - 1 && sy == SY - 1);
        clk_cycle();
      end
    last_pix = 0;
    // trailing pixels after the frame must be ignored
    for (int i = 0; i < S; i++) begin cam_valid = 1; cam_pixel = 16'h0000; clk_cycle(); end
    cam_valid = 0;
  endtask

  task automatic do_scan(input int n);
    scx = 0; scy = 0; scan_en = 1;
    for (int i = 0; i < n; i++) clk_cycle();
    scan_en = 0;
  endtask

  task automatic do_reset();
    reset = 1; cam_frame_start = 0; cam_valid = 0; cam_pixel = 0;
    next_pixel = 0; x = 0; y = 0; cx = 0; cy = 0; scan_en = 0; last_pix = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_color", 32'(color), 32'h0);
    chk("rst_swap_pending", 32'(swap_pending), 32'h0);
    chk("rst_frames_done", 32'(frames_done), 32'h0);
    chk("rst_frames_dropped", 32'(frames_dropped), 32'h0);
    reset = 0; m_pend = 0; m_done = 0; m_drop = 0; shown_ok = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // basic full frame, then swap at display origin
    do_reset();
    send_frame(0, 16'hF800, -1);
    do_scan(256);

    // averaging in window 0 of row 0
    do_reset();
    send_frame(1, 16'h0000, -1);
    do_scan(128);

    // two frames without a display boundary -> one drop, newest shown
    do_reset();
    send_frame(0, 16'h1234, -1);
    send_frame(0, 16'h5678, -1);
    do_scan(128);

    // aborted frame then a full frame
    do_reset();
    send_frame(0, 16'h3333, 20);
    send_frame(0, 16'hFFFF, -1);
    do_scan(128);

    // tear-free: scan continuously while the next frame is written
    scx = 0; scy = 0; scan_en = 1;
    send_frame(2, 16'h0000, -1);
    for (int i = 0; i < 384; i++) clk_cycle();
    scan_en = 0;

    // reset while ACTIVE; pixels without frame_start are ignored
    send_frame(0, 16'h1111, 20);
    do_reset();
    for (int i = 0; i < SX * SY; i++) begin
      cam_valid = 1; cam_pixel = 16'hABCD; clk_cycle();
    end
    cam_valid = 0;
    send_frame(2, 16'h0000, -1);
    do_scan(128);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
